// File: rtl/bcd_counter6.sv
// Six-digit BCD up/down counter stepped by a prescaler every TICK_DIV enabled
// cycles, with synchronous clear/load and one-cycle tick/wrap pulses.
module bcd_counter6 #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up,
  input  logic        clear,
  input  logic        load,
  input  logic [23:0] load_val,
  output logic [23:0] digits,
  output logic        tick,
  output logic        wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [23:0]   r_digits;
  logic          r_tick;
  logic          r_wrap;

  logic [6:0]    w_carry;
  logic [6:0]    w_borrow;
  logic [23:0]   w_inc;
  logic [23:0]   w_dec;
  logic [23:0]   w_sat;
  logic          w_presc_end;

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;
  assign w_presc_end = (r_presc == PRESC_MAX);

  // Per-digit ripple: carry/borrow propagates only through digits at 9/0,
  // so the final carry/borrow out doubles as the wrap indication.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      logic [3:0] w_d;
      logic [3:0] w_lv;
      assign w_d  = r_digits[4*gi +: 4];
      assign w_lv = load_val[4*gi +: 4];

      assign w_inc[4*gi +: 4] = !w_carry[gi]  ? w_d :
                                (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
      assign w_carry[gi+1]    = w_carry[gi] && (w_d == 4'd9);

      assign w_dec[4*gi +: 4] = !w_borrow[gi] ? w_d :
                                (w_d == 4'd0) ? 4'd9 : w_d - 4'd1;
      assign w_borrow[gi+1]   = w_borrow[gi] && (w_d == 4'd0);

      assign w_sat[4*gi +: 4] = (w_lv > 4'd9) ? 4'd9 : w_lv;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc  <= '0;
      r_digits <= '0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (clear) begin
        r_presc  <= '0;
        r_digits <= '0;
      end else if (load) begin
        r_presc  <= '0;
        r_digits <= w_sat;
      end else if (en) begin
        if (w_presc_end) begin
          r_presc  <= '0;
          r_digits <= up ? w_inc : w_dec;
          r_tick   <= 1'b1;
          r_wrap   <= up ? w_carry[6] : w_borrow[6];
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  assign digits = r_digits;
  assign tick   = r_tick;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_bcd_counter6.sv
// Directed bench for bcd_counter6 with TICK_DIV=4: a vector table applied in
// order plus hand-written sequences for enable gating and async reset.
module tb_bcd_counter6;

  logic        clk;
  logic        reset;
  logic        en;
  logic        up;
  logic        clear;
  logic        load;
  logic [23:0] load_val;
  logic [23:0] digits;
  logic        tick;
  logic        wrap;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic        up;
    logic        clear;
    logic        load;
    logic [23:0] lv;
    int          n;
    logic [23:0] exp_d;
    logic        exp_t;
    logic        exp_w;
  } vec_t;

  vec_t vecs[$];

  bcd_counter6 #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up      (up),
    .clear   (clear),
    .load    (load),
    .load_val(load_val),
    .digits  (digits),
    .tick    (tick),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic u, input logic c, input logic l,
                     input logic [23:0] lv, input int n,
                     input logic [23:0] d, input logic t, input logic w);
    vec_t v;
    v.en = e; v.up = u; v.clear = c; v.load = l; v.lv = lv; v.n = n;
    v.exp_d = d; v.exp_t = t; v.exp_w = w;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [23:0] lv);
    en = e; up = u; clear = c; load = l; load_val = lv;
  endtask

  initial begin
    //   en up cl ld load_val   n    digits     t  w
    add(0, 1, 0, 0, 24'h0,      3,   24'h000000, 0, 0);
    add(1, 1, 0, 0, 24'h0,      3,   24'h000000, 0, 0);
    add(1, 1, 0, 0, 24'h0,      1,   24'h000001, 1, 0);
    add(1, 1, 0, 0, 24'h0,      36,  24'h000010, 1, 0);
    add(0, 1, 0, 1, 24'h999998, 1,   24'h999998, 0, 0);
    add(1, 1, 0, 0, 24'h0,      4,   24'h999999, 1, 0);
    add(1, 1, 0, 0, 24'h0,      4,   24'h000000, 1, 1);
    add(1, 1, 0, 0, 24'h0,      1,   24'h000000, 0, 0);
    add(0, 0, 0, 1, 24'h000100, 1,   24'h000100, 0, 0);
    add(1, 0, 0, 0, 24'h0,      4,   24'h000099, 1, 0);
    add(1, 0, 0, 0, 24'h0,      396, 24'h000000, 1, 0);
    add(1, 0, 0, 0, 24'h0,      4,   24'h999999, 1, 1);
    add(0, 0, 0, 1, 24'h00FA37, 1,   24'h009937, 0, 0);
    add(1, 1, 1, 1, 24'h123456, 1,   24'h000000, 0, 0);
    add(1, 1, 0, 1, 24'h012345, 1,   24'h012345, 0, 0);
    add(1, 1, 0, 0, 24'h0,      3,   24'h012345, 0, 0);
    add(1, 1, 0, 1, 24'h000500, 1,   24'h000500, 0, 0);
    add(1, 1, 0, 0, 24'h0,      3,   24'h000500, 0, 0);
    add(1, 1, 0, 0, 24'h0,      1,   24'h000501, 1, 0);
    add(1, 1, 0, 0, 24'h0,      3,   24'h000501, 0, 0);
    add(1, 1, 1, 0, 24'h0,      1,   24'h000000, 0, 0);
    add(1, 1, 0, 0, 24'h0,      2,   24'h000000, 0, 0);
    add(1, 0, 0, 0, 24'h0,      2,   24'h999999, 1, 1);
    add(0, 1, 0, 1, 24'h000009, 1,   24'h000009, 0, 0);
    add(1, 1, 0, 0, 24'h0,      4,   24'h000010, 1, 0);
    add(0, 1, 0, 1, 24'h099999, 1,   24'h099999, 0, 0);
    add(1, 1, 0, 0, 24'h0,      4,   24'h100000, 1, 0);
    add(0, 0, 0, 1, 24'h100000, 1,   24'h100000, 0, 0);
    add(1, 0, 0, 0, 24'h0,      4,   24'h099999, 1, 0);

    reset = 1'b0;
    drive(0, 1, 0, 0, 24'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits", digits, 24'h000000);
    chk("reset_tick", {23'b0, tick}, 24'h0);
    chk("reset_wrap", {23'b0, wrap}, 24'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].en, vecs[k].up, vecs[k].clear, vecs[k].load, vecs[k].lv);
      repeat (vecs[k].n) @(posedge clk);
      #1;
      $display("vec %0d: digits=%h tick=%b wrap=%b", k, digits, tick, wrap);
      chk($sformatf("vec%0d_digits", k), digits, vecs[k].exp_d);
      chk($sformatf("vec%0d_tick", k), {23'b0, tick}, {23'b0, vecs[k].exp_t});
      chk($sformatf("vec%0d_wrap", k), {23'b0, wrap}, {23'b0, vecs[k].exp_w});
    end

    // Per-cycle tick cadence over 40 enabled cycles from a cleared state
    @(negedge clk);
    drive(0, 1, 1, 0, 24'h0);
    @(negedge clk);
    drive(1, 1, 0, 0, 24'h0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("cad%0d_tick", i), {23'b0, tick}, {23'b0, (i % 4) == 3});
      chk($sformatf("cad%0d_wrap", i), {23'b0, wrap}, 24'h0);
    end
    chk("cad_digits", digits, 24'h000010);
    $display("seq cadence: digits=%h", digits);

    // Enable gating: 3 enabled, 10 disabled, then the very next enabled edge steps
    @(negedge clk);
    drive(0, 1, 1, 0, 24'h0);
    @(negedge clk);
    drive(1, 1, 0, 0, 24'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("gate_pre", digits, 24'h000000);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("gate_hold%0d", i), {digits[22:0], tick}, 24'h0);
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("gate_step_digits", digits, 24'h000001);
    chk("gate_step_tick", {23'b0, tick}, 24'h1);
    $display("seq gate: digits=%h tick=%b", digits, tick);

    // Asynchronous reset mid-interval at 012345
    @(negedge clk);
    drive(0, 1, 0, 1, 24'h012345);
    @(negedge clk);
    drive(1, 1, 0, 0, 24'h0);
    repeat (2) @(posedge clk);
    #2;
    chk("areset_pre", digits, 24'h012345);
    reset = 1'b0;
    #1;
    chk("areset_now", digits, 24'h000000);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("areset_wait%0d", i), {digits[22:0], tick}, 24'h0);
    end
    @(posedge clk);
    #1;
    chk("areset_step_digits", digits, 24'h000001);
    chk("areset_step_tick", {23'b0, tick}, 24'h1);
    $display("seq areset: digits=%h tick=%b", digits, tick);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter6.md
BCD_COUNTER6 -- requirements
Module: bcd_counter6

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per count step (1 Hz at 50 MHz); legal range 2..2^26.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  count enable; gates prescaler and stepping.
REQ-005 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 SHALL have port clear  input  1  synchronous clear of count and prescaler.
REQ-007 SHALL have port load  input  1  synchronous load strobe.
REQ-008 SHALL have port load_val  input  24  six BCD nibbles to load; digit0 (least significant) at [3:0].
REQ-009 SHALL have port digits  output  24  registered six-digit BCD count, digit0 at [3:0], digit5 at [23:20]; each nibble feeds one sevenseg decoder.
REQ-010 SHALL have port tick  output  1  one-cycle pulse in the cycle digits takes a stepped value.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse when a step rolls over 999999->000000 or 000000->999999.

Function
REQ-012 SHALL keep a prescaler counting 0..TICK_DIV-1; increments only when en=1; holds when en=0.
REQ-013 SHALL generate a step when en=1 and prescaler = TICK_DIV-1; prescaler returns to 0 the same edge.
REQ-014 SHALL apply a step so that digits, tick and wrap update on the same rising edge; digits changes exactly TICK_DIV enabled cycles after prescaler is 0.
REQ-015 SHALL increment in BCD: digit at 9 becomes 0 and carries into the next digit; 999999 wraps to 000000 with wrap=1.
REQ-016 SHALL decrement in BCD: digit at 0 becomes 9 and borrows from the next digit; 000000 wraps to 999999 with wrap=1.
REQ-017 SHALL sample up only in the step cycle; changing up mid-interval does not reset the prescaler.
REQ-018 SHALL give priority clear > load > step within one cycle.
REQ-019 SHALL on clear set digits=000000, prescaler=0, tick=0, wrap=0 next edge, regardless of en or load.
REQ-020 SHALL on load (clear=0) set digits=load_val with any nibble >9 saturated to 9, prescaler=0, tick=0, wrap=0.
REQ-021 SHALL suppress a step coinciding with clear or load; no tick or wrap for that cycle.
REQ-022 SHALL drive tick and wrap low in every cycle except a step cycle; wrap implies tick.
REQ-023 SHALL drive every digits nibble in 0..9 at all times after reset.

Reset
REQ-024 SHALL, while reset=0, asynchronously force digits=000000, prescaler=0, tick=0, wrap=0.
REQ-025 SHALL resume counting from prescaler 0 at the first rising edge after reset deasserts; reset mid-interval discards the partial count.

Verification (TICK_DIV=4)
REQ-026 Reset then en=1, up=1 for 40 cycles -> digits=000010, tick pulses every 4th cycle, wrap never high.
REQ-027 load load_val=0x999998, en=1, up=1 -> after 4 cycles 999999, after 8 cycles 000000 with tick=1 and wrap=1 in that cycle only.
REQ-028 load 0x000100, up=0, 4 cycles -> 000099; then count to 000000 and one more step -> 999999 with wrap=1.
REQ-029 load 0x00FA37 -> digits=0x009937 (nibbles >9 saturated); clear and load asserted together -> digits=000000.
REQ-030 en=1 for 3 cycles, en=0 for 10 cycles, en=1 -> digits unchanged while en=0; step occurs on 1st enabled cycle after resume.
REQ-031 reset pulsed low asynchronously between edges mid-count at 012345 -> digits=000000 immediately; first step 4 enabled cycles after release.
